// File: rtl/ahb_req_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_req_decoder_if
// Description : Bundle of the AHB master-side request/response signals seen
//               by ahb_req_decoder. The "slave" modport is the decoder's view
//               of the bus. The "master" modport is the view of whatever
//               drives the master, arbiter and slave side of the bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_req_decoder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int SLAVE_NUM  = 4,
    parameter int SEL_BITS   = 2
);
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic [2:0]            hburst;        // AHB HBURST encoding
    logic                  hready_in;
    logic                  hresp_in;
    logic [SLAVE_NUM-1:0]  hgrant;
    logic [SLAVE_NUM-1:0]  hreq;
    logic                  hready_out;
    logic                  hresp_out;
    logic [SEL_BITS-1:0]   slave_sel;
    logic                  burst_active;

    modport slave (
        input  haddr, htrans, hburst, hready_in, hresp_in, hgrant,
        output hreq, hready_out, hresp_out, slave_sel, burst_active
    );

    modport master (
        output haddr, htrans, hburst, hready_in, hresp_in, hgrant,
        input  hreq, hready_out, hresp_out, slave_sel, burst_active
    );
endinterface
`default_nettype wire

// File: rtl/ahb_req_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ahb_req_decoder
// Description : Per-master AHB request decoder. It decodes the slave index
//               from the address and requests that slave's arbiter. It holds
//               the master off until the grant arrives, then tracks burst
//               beats to decide when to release the request. Out-of-range
//               addresses and request timeouts get a two-cycle ERROR
//               response.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_req_decoder #(
    parameter int SLAVE_NUM   = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int SEL_LSB     = 28,
    parameter int SEL_BITS    = 2,
    parameter int REQ_TIMEOUT = 255
) (
    input  wire logic          hclk,
    input  wire logic          hreset_n,
    ahb_req_decoder_if.slave   bus
);

    localparam int WAIT_W = (REQ_TIMEOUT < 1) ? 1 : $clog2(REQ_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(REQ_TIMEOUT);
    localparam logic [4:0]        BEAT_MAX = 5'd31;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_ERR1    = 3'd3,
        ST_ERR2    = 3'd4
    } state_t;

    state_t              state_q,     state_d;
    logic [SEL_BITS-1:0] slave_sel_q, slave_sel_d;
    logic [2:0]          burst_q,     burst_d;
    logic [WAIT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic [4:0]          beat_cnt_q,  beat_cnt_d;

    logic [SEL_BITS-1:0]  addr_index;
    logic                 index_valid;
    logic [SLAVE_NUM-1:0] sel_onehot;
    logic                 grant_sel;
    logic                 beat_valid;
    logic [4:0]           burst_len_w;
    logic                 req_phase;
    logic                 hready_out_c;
    logic                 hresp_out_c;
    logic                 unused_addr;

    // Number of beats in a fixed-length burst. INCR is unbounded, so its
    // value is never used.
    function automatic logic [4:0] burst_len(input logic [2:0] hb);
        case (hb)
            HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
            HBURST_INCR:                  burst_len = 5'd0;
            default:                      burst_len = 5'd1;
        endcase
    endfunction

    assign addr_index  = bus.haddr[SEL_LSB +: SEL_BITS];
    assign index_valid = (int'(addr_index) < SLAVE_NUM);
    assign unused_addr = ^bus.haddr;
    assign sel_onehot  = SLAVE_NUM'(1) << slave_sel_q;
    assign grant_sel   = |(bus.hgrant & sel_onehot);
    assign beat_valid  = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);
    assign burst_len_w = burst_len(burst_q);
    assign req_phase   = (state_q == ST_REQUEST) || (state_q == ST_ACTIVE);

    // The request is derived purely from state, so it drops as soon as the
    // state leaves REQUEST/ACTIVE. That includes an asynchronous reset.
    assign bus.hreq         = req_phase ? sel_onehot : '0;
    assign bus.burst_active = req_phase;
    assign bus.slave_sel    = slave_sel_q;
    assign bus.hready_out   = hready_out_c;
    assign bus.hresp_out    = hresp_out_c;

    // Next-state, counter and master-response logic.
    always_comb begin
        state_d      = state_q;
        slave_sel_d  = slave_sel_q;
        burst_d      = burst_q;
        wait_cnt_d   = wait_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        hready_out_c = 1'b1;
        hresp_out_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Stall a NONSEQ until its slave has granted the bus.
                hready_out_c = (bus.htrans != HTRANS_NONSEQ);
                if (bus.htrans == HTRANS_NONSEQ) begin
                    if (index_valid) begin
                        slave_sel_d = addr_index;
                        burst_d     = bus.hburst;
                        wait_cnt_d  = '0;
                        beat_cnt_d  = '0;
                        state_d     = ST_REQUEST;
                    end else begin
                        state_d = ST_ERR1;
                    end
                end
            end

            ST_REQUEST: begin
                hready_out_c = 1'b0;
                if (grant_sel) begin
                    state_d = ST_ACTIVE;
                end else if (wait_cnt_q == WAIT_MAX) begin
                    state_d = ST_ERR1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            ST_ACTIVE: begin
                // Without the grant the master is stalled and nothing counts.
                hready_out_c = bus.hready_in & grant_sel;
                hresp_out_c  = bus.hresp_in & grant_sel;
                if (bus.hready_in && bus.hresp_in && grant_sel) begin
                    state_d = ST_IDLE;
                end else if (hready_out_c) begin
                    if (beat_valid && (beat_cnt_q != BEAT_MAX)) begin
                        beat_cnt_d = beat_cnt_q + 5'd1;
                    end
                    if (burst_q == HBURST_INCR) begin
                        // The first accepted beat is the NONSEQ that opened
                        // the burst. Only a later NONSEQ starts a new
                        // transfer, and that transfer must be decoded again.
                        if ((bus.htrans == HTRANS_IDLE) ||
                            ((bus.htrans == HTRANS_NONSEQ) && (beat_cnt_q != 5'd0))) begin
                            state_d = ST_IDLE;
                        end
                    end else if (beat_valid && ((beat_cnt_q + 5'd1) == burst_len_w)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_ERR1: begin
                hready_out_c = 1'b0;
                hresp_out_c  = 1'b1;
                state_d      = ST_ERR2;
            end

            ST_ERR2: begin
                hready_out_c = 1'b1;
                hresp_out_c  = 1'b1;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched transfer attributes, cleared asynchronously.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q     <= ST_IDLE;
            slave_sel_q <= '0;
            burst_q     <= HBURST_SINGLE;
            wait_cnt_q  <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            slave_sel_q <= slave_sel_d;
            burst_q     <= burst_d;
            wait_cnt_q  <= wait_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_req_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_req_decoder
// Description : Directed, table-driven bench for ahb_req_decoder. The DUT is
//               built with SLAVE_NUM=3, so that 0xF000_0000 decodes out of
//               range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_req_decoder;

    localparam logic [1:0] ID = 2'd0;
    localparam logic [1:0] BZ = 2'd1;
    localparam logic [1:0] NS = 2'd2;
    localparam logic [1:0] SQ = 2'd3;

    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR   = 3'd1;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR8  = 3'd5;
    localparam logic [2:0] B_INCR16 = 3'd7;

    localparam logic [31:0] A0 = 32'h0000_0000;
    localparam logic [31:0] A1 = 32'h1000_0000;
    localparam logic [31:0] A2 = 32'h2000_0000;
    localparam logic [31:0] AF = 32'hF000_0000;

    typedef struct {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic [2:0]  hburst;
        logic        hready_in;
        logic        hresp_in;
        logic [2:0]  hgrant;
        logic [2:0]  exp_hreq;
        logic        exp_rdy;
        logic        exp_resp;
        logic [1:0]  exp_sel;
        logic        exp_act;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    ahb_req_decoder_if #(.ADDR_WIDTH(32), .SLAVE_NUM(3), .SEL_BITS(2)) bus_if ();

    ahb_req_decoder #(
        .SLAVE_NUM   (3),
        .ADDR_WIDTH  (32),
        .SEL_LSB     (28),
        .SEL_BITS    (2),
        .REQ_TIMEOUT (255)
    ) dut (
        .hclk     (clk),
        .hreset_n (rst_n),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [1:0] t, input logic [2:0] b,
                       input logic ri, input logic rs, input logic [2:0] g,
                       input logic [2:0] eq, input logic er, input logic ep,
                       input logic [1:0] es, input logic ea);
        vec_t v;
        v.haddr = a; v.htrans = t; v.hburst = b; v.hready_in = ri; v.hresp_in = rs;
        v.hgrant = g; v.exp_hreq = eq; v.exp_rdy = er; v.exp_resp = ep;
        v.exp_sel = es; v.exp_act = ea;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic [2:0] b,
                         input logic ri, input logic rs, input logic [2:0] g);
        bus_if.haddr = a; bus_if.htrans = t; bus_if.hburst = b;
        bus_if.hready_in = ri; bus_if.hresp_in = rs; bus_if.hgrant = g;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;

        // Each row is one clock cycle:
        // haddr, htrans, hburst, hready_in, hresp_in, hgrant | hreq, hready_out, hresp_out, slave_sel, burst_active
        // SINGLE to slave 1, grant arrives in the second REQUEST cycle.
        add(A0, ID, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b1, 1'b0, 2'd0, 1'b0);
        add(A1, NS, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(A1, NS, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b010, 1'b0, 1'b0, 2'd1, 1'b1);
        add(A1, NS, B_SINGLE, 1'b1, 1'b0, 3'b010,  3'b010, 1'b0, 1'b0, 2'd1, 1'b1);
        add(A1, NS, B_SINGLE, 1'b1, 1'b0, 3'b010,  3'b010, 1'b1, 1'b0, 2'd1, 1'b1);
        add(A0, ID, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b1, 1'b0, 2'd1, 1'b0);
        // INCR4 to slave 2 with one BUSY beat.
        add(A2, NS, B_INCR4,  1'b1, 1'b0, 3'b100,  3'b000, 1'b0, 1'b0, 2'd1, 1'b0);
        add(A2, NS, B_INCR4,  1'b1, 1'b0, 3'b100,  3'b100, 1'b0, 1'b0, 2'd2, 1'b1);
        add(A2, NS, B_INCR4,  1'b1, 1'b0, 3'b100,  3'b100, 1'b1, 1'b0, 2'd2, 1'b1);
        add(A2, SQ, B_INCR4,  1'b1, 1'b0, 3'b100,  3'b100, 1'b1, 1'b0, 2'd2, 1'b1);
        add(A2, BZ, B_INCR4,  1'b1, 1'b0, 3'b100,  3'b100, 1'b1, 1'b0, 2'd2, 1'b1);
        add(A2, SQ, B_INCR4,  1'b1, 1'b0, 3'b100,  3'b100, 1'b1, 1'b0, 2'd2, 1'b1);
        add(A2, SQ, B_INCR4,  1'b1, 1'b0, 3'b100,  3'b100, 1'b1, 1'b0, 2'd2, 1'b1);
        add(A0, ID, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b1, 1'b0, 2'd2, 1'b0);
        // Out-of-range slave index; the NONSEQ held during ERR1/ERR2 is ignored.
        add(AF, NS, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b0, 1'b0, 2'd2, 1'b0);
        add(A0, NS, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b0, 1'b1, 2'd2, 1'b0);
        add(A0, NS, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b1, 1'b1, 2'd2, 1'b0);
        add(A0, ID, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b1, 1'b0, 2'd2, 1'b0);
        // INCR8 to slave 0 with the grant lost for 3 cycles after beat 3.
        add(A0, NS, B_INCR8,  1'b1, 1'b0, 3'b001,  3'b000, 1'b0, 1'b0, 2'd2, 1'b0);
        add(A0, NS, B_INCR8,  1'b1, 1'b0, 3'b001,  3'b001, 1'b0, 1'b0, 2'd0, 1'b1);
        add(A0, NS, B_INCR8,  1'b1, 1'b0, 3'b001,  3'b001, 1'b1, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 2; i++)
            add(A0, SQ, B_INCR8, 1'b1, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++)
            add(A0, SQ, B_INCR8, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++)
            add(A0, SQ, B_INCR8, 1'b1, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 2'd0, 1'b1);
        add(A0, ID, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b1, 1'b0, 2'd0, 1'b0);
        // INCR4 to slave 1 cut short by a slave ERROR on beat 2.
        add(A1, NS, B_INCR4,  1'b1, 1'b0, 3'b010,  3'b000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(A1, NS, B_INCR4,  1'b1, 1'b0, 3'b010,  3'b010, 1'b0, 1'b0, 2'd1, 1'b1);
        add(A1, NS, B_INCR4,  1'b1, 1'b0, 3'b010,  3'b010, 1'b1, 1'b0, 2'd1, 1'b1);
        add(A1, SQ, B_INCR4,  1'b1, 1'b1, 3'b010,  3'b010, 1'b1, 1'b1, 2'd1, 1'b1);
        add(A0, ID, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b1, 1'b0, 2'd1, 1'b0);
        // Undefined-length INCR to slave 2, ended by IDLE.
        add(A2, NS, B_INCR,   1'b1, 1'b0, 3'b100,  3'b000, 1'b0, 1'b0, 2'd1, 1'b0);
        add(A2, NS, B_INCR,   1'b1, 1'b0, 3'b100,  3'b100, 1'b0, 1'b0, 2'd2, 1'b1);
        add(A2, NS, B_INCR,   1'b1, 1'b0, 3'b100,  3'b100, 1'b1, 1'b0, 2'd2, 1'b1);
        add(A2, SQ, B_INCR,   1'b1, 1'b0, 3'b100,  3'b100, 1'b1, 1'b0, 2'd2, 1'b1);
        add(A2, SQ, B_INCR,   1'b0, 1'b0, 3'b100,  3'b100, 1'b0, 1'b0, 2'd2, 1'b1);
        add(A2, ID, B_INCR,   1'b1, 1'b0, 3'b100,  3'b100, 1'b1, 1'b0, 2'd2, 1'b1);
        add(A0, ID, B_SINGLE, 1'b1, 1'b0, 3'b000,  3'b000, 1'b1, 1'b0, 2'd2, 1'b0);

        // Reset state.
        rst_n = 1'b0;
        drive(A0, ID, B_SINGLE, 1'b1, 1'b0, 3'b000);
        #1;
        chk("reset_hreq", 0, 32'(bus_if.hreq), 32'h0);
        chk("reset_sel", 0, 32'(bus_if.slave_sel), 32'h0);
        chk("reset_active", 0, 32'(bus_if.burst_active), 32'h0);
        chk("reset_hresp", 0, 32'(bus_if.hresp_out), 32'h0);
        #11 rst_n = 1'b1;
        step();

        // Table-driven cycles.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].haddr, vecs[i].htrans, vecs[i].hburst,
                  vecs[i].hready_in, vecs[i].hresp_in, vecs[i].hgrant);
            @(negedge clk);
            chk("hreq", i, 32'(bus_if.hreq), 32'(vecs[i].exp_hreq));
            chk("hready_out", i, 32'(bus_if.hready_out), 32'(vecs[i].exp_rdy));
            chk("hresp_out", i, 32'(bus_if.hresp_out), 32'(vecs[i].exp_resp));
            chk("slave_sel", i, 32'(bus_if.slave_sel), 32'(vecs[i].exp_sel));
            chk("burst_active", i, 32'(bus_if.burst_active), 32'(vecs[i].exp_act));
            step();
        end

        // Request timeout: no grant, so hreq stays up for 256 cycles and then
        // the master gets ERR1/ERR2.
        drive(A0, NS, B_SINGLE, 1'b1, 1'b0, 3'b000);
        @(negedge clk);
        chk("to_stall", 0, 32'(bus_if.hready_out), 32'h0);
        step();
        n = 0;
        while (bus_if.hreq == 3'b001 && n < 300) begin
            n++;
            step();
        end
        chk("to_req_cycles", 0, 32'(n), 32'd256);
        drive(A0, ID, B_SINGLE, 1'b1, 1'b0, 3'b000);
        #1;
        chk("to_err1_hreq", 0, 32'(bus_if.hreq), 32'h0);
        chk("to_err1_rdy", 0, 32'(bus_if.hready_out), 32'h0);
        chk("to_err1_resp", 0, 32'(bus_if.hresp_out), 32'h1);
        step();
        chk("to_err2_rdy", 0, 32'(bus_if.hready_out), 32'h1);
        chk("to_err2_resp", 0, 32'(bus_if.hresp_out), 32'h1);
        step();
        chk("to_idle_resp", 0, 32'(bus_if.hresp_out), 32'h0);
        chk("to_idle_active", 0, 32'(bus_if.burst_active), 32'h0);

        // Reset during beat 5 of INCR16 to slave 1, then a fresh request.
        drive(A1, NS, B_INCR16, 1'b1, 1'b0, 3'b010);
        step();                       // REQUEST
        step();                       // ACTIVE
        step();                       // beat 1 (NONSEQ) accepted
        bus_if.htrans = SQ;
        step();                       // beat 2
        step();                       // beat 3
        step();                       // beat 4
        @(negedge clk);
        chk("rst_pre_hreq", 0, 32'(bus_if.hreq), 32'h2);
        chk("rst_pre_rdy", 0, 32'(bus_if.hready_out), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_hreq", 0, 32'(bus_if.hreq), 32'h0);
        chk("rst_mid_active", 0, 32'(bus_if.burst_active), 32'h0);
        chk("rst_mid_sel", 0, 32'(bus_if.slave_sel), 32'h0);
        chk("rst_mid_resp", 0, 32'(bus_if.hresp_out), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(A2, NS, B_SINGLE, 1'b1, 1'b0, 3'b100);
        step();
        chk("rst_new_hreq", 0, 32'(bus_if.hreq), 32'h4);
        chk("rst_new_sel", 0, 32'(bus_if.slave_sel), 32'h2);
        chk("rst_new_rdy", 0, 32'(bus_if.hready_out), 32'h0);
        step();
        chk("rst_new_beat", 0, 32'(bus_if.hready_out), 32'h1);
        step();
        bus_if.htrans = ID;
        #1;
        chk("rst_new_done", 0, 32'(bus_if.hreq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_req_decoder.md
AHB_REQ_DECODER -- requirements
Module: ahb_req_decoder

Interface
REQ-001 SHALL have parameter SLAVE_NUM, default 4, number of slave ports/arbiters this master can request.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, master address width.
REQ-003 SHALL have parameter SEL_LSB, default 28, lowest address bit of the slave index field.
REQ-004 SHALL have parameter SEL_BITS, default 2, width of the slave index field haddr[SEL_LSB+:SEL_BITS].
REQ-005 SHALL have parameter REQ_TIMEOUT, default 255, maximum REQUEST-state cycles before error.
REQ-006 Port hclk  input  1  sole clock; all state on rising edge.
REQ-007 Port hreset_n  input  1  asynchronous, active-low reset.
REQ-008 Port haddr  input  ADDR_WIDTH  master address-phase address.
REQ-009 Port htrans  input  2  master transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
REQ-010 Port hburst  input  hburst_type  master burst type.
REQ-011 Port hready_in  input  1  HREADY from selected slave (post-mux).
REQ-012 Port hresp_in  input  1  HRESP from selected slave, 1 = ERROR.
REQ-013 Port hgrant  input  SLAVE_NUM  bit s = grant from arbiter of slave s for this master.
REQ-014 Port hreq  output  SLAVE_NUM  bit s = request to arbiter of slave s.
REQ-015 Port hready_out  output  1  HREADY returned to master.
REQ-016 Port hresp_out  output  1  HRESP returned to master.
REQ-017 Port slave_sel  output  SEL_BITS  registered index of target slave, drives data muxes.
REQ-018 Port burst_active  output  1  high in REQUEST and ACTIVE states.

Function
REQ-019 FSM states SHALL be IDLE, REQUEST, ACTIVE, ERR1, ERR2.
REQ-020 IDLE: hready_out SHALL be 0 when htrans==NONSEQ, else 1; hresp_out 0; hreq all 0.
REQ-021 IDLE + NONSEQ with index < SLAVE_NUM: SHALL latch index into slave_sel, latch hburst, clear counters, go REQUEST.
REQ-022 IDLE + NONSEQ with index >= SLAVE_NUM: SHALL go ERR1 without asserting any hreq bit.
REQ-023 hreq SHALL equal one-hot(slave_sel) in REQUEST and ACTIVE, else 0; hreq is state-derived, so it rises the cycle after NONSEQ is sampled.
REQ-024 REQUEST: hready_out 0; on hgrant[slave_sel]==1 go ACTIVE; wait counter increments each cycle without grant.
REQ-025 REQUEST: when wait counter reaches REQ_TIMEOUT without grant, SHALL drop hreq and go ERR1.
REQ-026 ACTIVE: hready_out SHALL be hready_in & hgrant[slave_sel]; hresp_out SHALL be hresp_in & hgrant[slave_sel].
REQ-027 ACTIVE: beat counter (5 bits) SHALL increment when hready_out==1 and htrans is NONSEQ or SEQ; BUSY and IDLE beats do not count.
REQ-028 Burst length: SINGLE 1; INCR4/WRAP4 4; INCR8/WRAP8 8; INCR16/WRAP16 16; INCR unbounded.
REQ-029 Fixed-length burst: on the counted beat making count equal length, SHALL go IDLE next cycle.
REQ-030 INCR: SHALL go IDLE when hready_out==1 and htrans is IDLE or NONSEQ.
REQ-031 Grant loss in ACTIVE (hgrant[slave_sel]==0): SHALL hold hready_out 0, keep hreq asserted, remain ACTIVE, counter frozen.
REQ-032 Slave error in ACTIVE (hresp_in==1 and hready_in==1 with grant): SHALL go IDLE next cycle regardless of remaining beats.
REQ-033 ERR1: hready_out 0, hresp_out 1, next ERR2; ERR2: hready_out 1, hresp_out 1, next IDLE.
REQ-034 Counters SHALL saturate, never wrap; a NONSEQ during ERR1/ERR2 SHALL be ignored.

Reset
REQ-035 hreset_n low SHALL immediately force IDLE, hreq 0, slave_sel 0, latched burst SINGLE, counters 0, burst_active 0, hresp_out 0.
REQ-036 Reset asserted mid-burst SHALL drop hreq in the same cycle without completing the burst; operation resumes on the first edge after release.

Verification
REQ-037 SINGLE to haddr 0x1000_0000, grant after 2 cycles -> hreq=0b0010 for 3 cycles, slave_sel=1, one hready_out pulse, IDLE after.
REQ-038 INCR4 to slave 2, grant held, one BUSY inserted mid-burst -> 4 counted beats, hreq=0b0100 dropped the cycle after the 4th beat.
REQ-039 NONSEQ to haddr 0xF000_0000 with SLAVE_NUM=3 -> hreq stays 0; hready_out/hresp_out = 0/1 then 1/1, then IDLE.
REQ-040 INCR8, hgrant deasserted for 3 cycles after beat 3 -> hready_out 0 for those cycles, hreq held, 8 beats total.
REQ-041 REQUEST with no grant for 256 cycles -> hreq drops, ERR1/ERR2 response.
REQ-042 hreset_n pulsed low during beat 5 of INCR16 -> hreq=0 immediately, IDLE, new NONSEQ after release requests normally.
